// File: rtl/dcache.sv
// rtl/dcache.sv - 8-line direct-mapped write-back, write-allocate data cache
// Blocks are 4 bytes; misses refill through a single-block memory port.
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t      state, next_state;
    logic [7:0]  valid, dirty;
    logic [2:0]  tag_mem  [8];
    logic [31:0] data_mem [8];
    logic        first_cycle;

    logic [2:0]  tag, index;
    logic [1:0]  offset;
    logic        hit, access;
    logic [31:0] line_data;
    logic [7:0]  sel_byte;

    assign tag       = address[7:5];
    assign index     = address[4:2];
    assign offset    = address[1:0];
    assign line_data = data_mem[index];
    assign hit       = valid[index] && (tag_mem[index] == tag);
    assign access    = read | write;
    assign busywait  = access && !(state == IDLE && hit);

    always_comb begin
        sel_byte = line_data[7:0];
        case (offset)
            2'd1:    sel_byte = line_data[15:8];
            2'd2:    sel_byte = line_data[23:16];
            2'd3:    sel_byte = line_data[31:24];
            default: sel_byte = line_data[7:0];
        endcase
    end

    // A simultaneous read and write is a store, so it returns no load data.
    assign readdata = (read && !write && hit) ? sel_byte : 8'h00;

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {tag, index};
        mem_writedata = line_data;
        case (state)
            IDLE: begin
                if (access && !hit)
                    next_state = (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_mem[index], index};
                if (!first_cycle && !mem_busywait)
                    next_state = FETCH;
            end
            FETCH: begin
                mem_read = 1'b1;
                if (!first_cycle && !mem_busywait)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // first_cycle masks a stale low mem_busywait seen on the edge ending the entry cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= 8'h00;
            dirty       <= 8'h00;
            first_cycle <= 1'b0;
        end else begin
            state       <= next_state;
            first_cycle <= (next_state != state);
            if (state == FETCH && next_state == IDLE) begin
                data_mem[index] <= mem_readdata;
                tag_mem[index]  <= tag;
                valid[index]    <= 1'b1;
                dirty[index]    <= 1'b0;
            end else if (state == IDLE && write && hit) begin
                data_mem[index][{offset, 3'b000} +: 8] <= writedata;
                dirty[index] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - scoreboard bench for dcache with a fixed-latency block memory
// Expected load data and memory transactions are queued by stimulus and popped by monitors.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [7:0]  writedata = 8'h00;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_busywait = 1'b0;

    dcache dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    localparam int LAT = 5;

    int          compared = 0;
    int          failed   = 0;
    logic [7:0]  expq [$];
    mem_txn_t    memq [$];
    logic [31:0] mem  [64];
    bit          mem_busy = 0;
    int          mem_cnt  = 0;
    mem_txn_t    cur;
    bit          aborting = 0;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: an accepted access is any cycle with a request and busywait low.
    always @(negedge CLK) begin
        if ((read || write) && !busywait && !RESET) begin
            if (expq.size() == 0) begin
                compared++; failed++;
                $display("FAIL unexpected_response: got readdata %h expected none", readdata);
            end else begin
                chk("readdata", {24'h0, readdata}, {24'h0, expq.pop_front()});
            end
        end
    end

    // Block memory model; it checks each request against the expected transaction queue.
    always @(negedge CLK) begin
        chk("rd_wr_exclusive", {31'h0, mem_read && mem_write}, 32'h0);
        if (mem_busy) begin
            if (!aborting) begin
                chk("mem_req_held", {30'h0, mem_write, mem_read}, {30'h0, cur.wr, !cur.wr});
                chk("mem_addr_held", {26'h0, mem_address}, {26'h0, cur.addr});
            end
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busy     = 0;
                mem_busywait = 1'b0;
                if (cur.wr) mem[cur.addr] = cur.data;
                else        mem_readdata  = mem[cur.addr];
            end
        end else if (mem_read || mem_write) begin
            if (memq.size() == 0) begin
                compared++; failed++;
                $display("FAIL unexpected_mem_txn: got wr=%0b addr %h expected none", mem_write, mem_address);
            end else begin
                mem_txn_t e;
                e = memq.pop_front();
                chk("mem_txn_kind", {30'h0, mem_write, mem_read}, {30'h0, e.wr, !e.wr});
                chk("mem_txn_addr", {26'h0, mem_address}, {26'h0, e.addr});
                if (e.wr) chk("mem_txn_wdata", mem_writedata, e.data);
            end
            cur.wr       = mem_write;
            cur.addr     = mem_address;
            cur.data     = mem_writedata;
            mem_busy     = 1;
            mem_cnt      = LAT;
            mem_busywait = 1'b1;
        end
    end

    task automatic exp_mem(input bit wr, input logic [5:0] a, input logic [31:0] d);
        mem_txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        memq.push_back(t);
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] exp, output int cycles);
        bit done;
        @(posedge CLK); #1;
        read = rd; write = wr; address = a; writedata = wd;
        expq.push_back(exp);
        done = 0;
        cycles = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (!busywait) done = 1;
            else cycles++;
        end
        if (!done) begin
            compared++; failed++;
            $display("FAIL access_timeout: addr %h still busy, expected completion", a);
        end
        @(posedge CLK); #1;
        read = 0; write = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h29] = 32'h44332211;
        mem[6'h12] = 32'hA1B2C3D4;

        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_mem_read",  {31'h0, mem_read},  32'h0);
        chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
        chk("reset_readdata",  {24'h0, readdata},  32'h0);
        chk("reset_busywait",  {31'h0, busywait},  32'h0);

        // Cold miss, then hits on the same line.
        exp_mem(0, 6'h09, 32'h0);
        access(1, 0, 8'h24, 8'h00, 8'hAA, cyc);
        access(1, 0, 8'h25, 8'h00, 8'hBB, cyc);
        chk("hit_latency_r25", cyc, 0);
        access(0, 1, 8'h26, 8'h5A, 8'h00, cyc);
        chk("hit_latency_w26", cyc, 0);
        access(1, 0, 8'h26, 8'h00, 8'h5A, cyc);
        chk("hit_latency_r26", cyc, 0);

        // Dirty conflict: write back old block, then fetch new tag.
        exp_mem(1, 6'h09, 32'hDD5ABBAA);
        exp_mem(0, 6'h29, 32'h0);
        access(1, 0, 8'hA4, 8'h00, 8'h11, cyc);
        access(1, 0, 8'hA7, 8'h00, 8'h44, cyc);
        chk("hit_latency_rA7", cyc, 0);

        // Clean conflict refetches the written-back block.
        exp_mem(0, 6'h09, 32'h0);
        access(1, 0, 8'h24, 8'h00, 8'hAA, cyc);

        // Read and write together behave as a store.
        access(1, 1, 8'h25, 8'h77, 8'h00, cyc);
        chk("hit_latency_rw25", cyc, 0);
        access(1, 0, 8'h25, 8'h00, 8'h77, cyc);

        // Reset in the middle of a fetch.
        exp_mem(0, 6'h12, 32'h0);
        @(posedge CLK); #1;
        read = 1; address = 8'h48;
        repeat (2) @(negedge CLK);
        chk("fetch_mem_read", {31'h0, mem_read}, 32'h1);
        @(posedge CLK); #1;
        aborting = 1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        read = 0;
        @(negedge CLK);
        chk("abort_mem_read",  {31'h0, mem_read},  32'h0);
        chk("abort_mem_write", {31'h0, mem_write}, 32'h0);
        repeat (10) @(posedge CLK);
        aborting = 0;

        exp_mem(0, 6'h12, 32'h0);
        access(1, 0, 8'h48, 8'h00, 8'hD4, cyc);
        chk("refetch_latency_nonzero", {31'h0, cyc > 0}, 32'h1);

        // Dirty line from before reset is discarded, not written back.
        exp_mem(0, 6'h09, 32'h0);
        access(1, 0, 8'h25, 8'h00, 8'hBB, cyc);

        repeat (5) @(posedge CLK);
        chk("expq_drained", expq.size(), 0);
        chk("memq_drained", memq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
